// File: rtl/toycpu_control.sv
`default_nettype none
//=============================================================================
// Module   : toycpu_control
// Brief    : Instruction sequencer for the toy CPU. Fetches 16-bit
//            instructions over a req/valid handshake, decodes them and
//            drives the ALU opcode, register-file selects/write-enable and
//            the immediate path. The ALU's registered flags resolve the
//            conditional jumps.
// Options  : CTRL_COND_BRANCH_EN - when defined, JZ/JC are decoded;
//            otherwise opcodes 0x4/0x5 are illegal.
// Revision : 1.0 - initial release
//=============================================================================
module toycpu_control #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        ADD_OP   = 4'h0,
   parameter logic [3:0]        MV_OP    = 4'h1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [15:0]       imem_data,
   output logic [3:0]        alu_op,
   output logic [3:0]        rf_rd_sel,
   output logic [3:0]        rf_rs_sel,
   output logic              rf_we,
   output logic              imm_sel,
   output logic [15:0]       imm,
   input  logic              cFlag,
   input  logic              zFlag,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              illegal
);

   // Reserved opcode that makes the ALU hold its flags.
   localparam logic [3:0] c_ALU_IDLE_OP = 4'hF;

   localparam logic [3:0] c_OPC_ADD  = 4'h0;
   localparam logic [3:0] c_OPC_MV   = 4'h1;
   localparam logic [3:0] c_OPC_LDI  = 4'h2;
   localparam logic [3:0] c_OPC_JMP  = 4'h3;
`ifdef CTRL_COND_BRANCH_EN
   localparam logic [3:0] c_OPC_JZ   = 4'h4;
   localparam logic [3:0] c_OPC_JC   = 4'h5;
`endif
   localparam logic [3:0] c_OPC_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [15:0]       r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic              r_illegal;
   logic [3:0]        r_alu_op;
   logic [3:0]        r_rd_sel;
   logic [3:0]        r_rs_sel;
   logic              r_we;
   logic              r_imm_sel;
   logic [15:0]       r_imm;
   logic              r_taken;
   logic [ADDR_W-1:0] r_target;

   logic [3:0]        w_op;
   logic [3:0]        w_dec_alu_op;
   logic              w_dec_we;
   logic              w_dec_imm_sel;
   logic              w_dec_taken;
   logic              w_dec_halt;
   logic              w_dec_illegal;

   assign w_op = r_ir[15:12];

`ifndef CTRL_COND_BRANCH_EN
   // Flags only matter for conditional jumps, which this build does not decode.
   logic w_unused_flags;
   assign w_unused_flags = cFlag ^ zFlag;
`endif

   // Decode the latched instruction; flags are sampled here, which is
   // already at least two edges after any preceding ADD updated them.
   always_comb begin
      w_dec_alu_op  = c_ALU_IDLE_OP;
      w_dec_we      = 1'b0;
      w_dec_imm_sel = 1'b0;
      w_dec_taken   = 1'b0;
      w_dec_halt    = 1'b0;
      w_dec_illegal = 1'b0;
      case (w_op)
         c_OPC_ADD: begin
            w_dec_alu_op = ADD_OP;
            w_dec_we     = 1'b1;
         end
         c_OPC_MV: begin
            w_dec_alu_op = MV_OP;
            w_dec_we     = 1'b1;
         end
         c_OPC_LDI: begin
            w_dec_alu_op  = MV_OP;
            w_dec_imm_sel = 1'b1;
            w_dec_we      = 1'b1;
         end
         c_OPC_JMP:  w_dec_taken = 1'b1;
`ifdef CTRL_COND_BRANCH_EN
         c_OPC_JZ:   w_dec_taken = zFlag;
         c_OPC_JC:   w_dec_taken = cFlag;
`endif
         c_OPC_HALT: w_dec_halt  = 1'b1;
         default:    w_dec_illegal = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: HALT is absorbing until reset.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH:   if (imem_valid) w_state_nxt = S_DECODE;
         S_DECODE:  w_state_nxt = (w_dec_halt || w_dec_illegal) ? S_HALT : S_EXECUTE;
         S_EXECUTE: w_state_nxt = S_FETCH;
         S_HALT:    w_state_nxt = S_HALT;
         default:   w_state_nxt = S_FETCH;
      endcase
   end

   // Instruction latch, registered controls (live only during EXECUTE) and PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir      <= '0;
         r_pc      <= RESET_PC;
         r_illegal <= 1'b0;
         r_alu_op  <= c_ALU_IDLE_OP;
         r_rd_sel  <= '0;
         r_rs_sel  <= '0;
         r_we      <= 1'b0;
         r_imm_sel <= 1'b0;
         r_imm     <= '0;
         r_taken   <= 1'b0;
         r_target  <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_valid) r_ir <= imem_data;
            end
            S_DECODE: begin
               if (w_dec_illegal) r_illegal <= 1'b1;
               if (!(w_dec_halt || w_dec_illegal)) begin
                  r_alu_op  <= w_dec_alu_op;
                  r_we      <= w_dec_we;
                  r_imm_sel <= w_dec_imm_sel;
                  r_rd_sel  <= r_ir[11:8];
                  r_rs_sel  <= r_ir[7:4];
                  r_imm     <= {8'h00, r_ir[7:0]};
                  r_taken   <= w_dec_taken;
                  r_target  <= r_ir[ADDR_W-1:0];
               end
            end
            S_EXECUTE: begin
               r_alu_op  <= c_ALU_IDLE_OP;
               r_we      <= 1'b0;
               r_imm_sel <= 1'b0;
               r_taken   <= 1'b0;
               r_pc      <= r_taken ? r_target
                                    : r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            default: begin
               r_pc <= r_pc;
            end
         endcase
      end
   end

   // Gating with rst_n keeps the request low while reset is held even though
   // the state already reads FETCH.
   assign imem_req  = rst_n && (r_state == S_FETCH);
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign alu_op    = r_alu_op;
   assign rf_rd_sel = r_rd_sel;
   assign rf_rs_sel = r_rs_sel;
   assign rf_we     = r_we;
   assign imm_sel   = r_imm_sel;
   assign imm       = r_imm;
   assign halted    = (r_state == S_HALT);
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_toycpu_control.sv
`default_nettype none
//=============================================================================
// Module   : tb_toycpu_control
// Brief    : Directed self-checking bench for toycpu_control. Instruction
//            memory is played by the bench, one instruction at a time.
// Revision : 1.0 - initial release
//=============================================================================
module tb_toycpu_control;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic        imem_valid;
   logic [15:0] imem_data;
   logic [3:0]  alu_op;
   logic [3:0]  rf_rd_sel;
   logic [3:0]  rf_rs_sel;
   logic        rf_we;
   logic        imm_sel;
   logic [15:0] imm;
   logic        cFlag;
   logic        zFlag;
   logic [11:0] pc;
   logic        halted;
   logic        illegal;

   int          n_checks;
   int          n_fail;
   logic [11:0] exp_pc;

   toycpu_control #(
      .ADDR_W   (12),
      .RESET_PC (12'h000),
      .ADD_OP   (4'h0),
      .MV_OP    (4'h1)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_data  (imem_data),
      .alu_op     (alu_op),
      .rf_rd_sel  (rf_rd_sel),
      .rf_rs_sel  (rf_rs_sel),
      .rf_we      (rf_we),
      .imm_sel    (imm_sel),
      .imm        (imm),
      .cFlag      (cFlag),
      .zFlag      (zFlag),
      .pc         (pc),
      .halted     (halted),
      .illegal    (illegal)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock, landing on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Serve one fetch at addr after `waits` empty cycles; returns in DECODE.
   task automatic issue(input logic [15:0] instr, input int waits, input logic [11:0] addr);
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", {20'd0, imem_addr}, {20'd0, addr});
      imem_valid = 1'b0;
      imem_data  = 16'hF000;
      for (int i = 0; i < waits; i++) begin
         cyc();
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", {20'd0, imem_addr}, {20'd0, addr});
         chk("wait_aluop", {28'd0, alu_op}, 32'hF);
      end
      imem_valid = 1'b1;
      imem_data  = instr;
      cyc();
      imem_valid = 1'b0;
      imem_data  = 16'hF000;
      chk("dec_req", {31'd0, imem_req}, 32'd0);
      chk("dec_we", {31'd0, rf_we}, 32'd0);
      chk("dec_aluop", {28'd0, alu_op}, 32'hF);
   endtask

   // From DECODE: step into EXECUTE and check the driven controls.
   task automatic exec_chk(input logic [3:0] op, input logic we, input logic isel,
                           input logic [3:0] rd, input logic [3:0] rs);
      cyc();
      chk("ex_aluop", {28'd0, alu_op}, {28'd0, op});
      chk("ex_we", {31'd0, rf_we}, {31'd0, we});
      chk("ex_immsel", {31'd0, imm_sel}, {31'd0, isel});
      if (we) begin
         chk("ex_rd", {28'd0, rf_rd_sel}, {28'd0, rd});
         chk("ex_rs", {28'd0, rf_rs_sel}, {28'd0, rs});
      end
   endtask

   // From EXECUTE: step back to FETCH and check the new PC.
   task automatic post_chk(input logic [11:0] npc);
      cyc();
      chk("post_pc", {20'd0, pc}, {20'd0, npc});
      chk("post_we", {31'd0, rf_we}, 32'd0);
      chk("post_aluop", {28'd0, alu_op}, 32'hF);
      chk("post_immsel", {31'd0, imm_sel}, 32'd0);
   endtask

   // Pulse reset (at a falling edge) and check it clears the core.
   task automatic pulse_rst();
      rst_n = 1'b0;
      #1;
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_pc", {20'd0, pc}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_req", {31'd0, imem_req}, 32'd1);
      chk("rel_addr", {20'd0, imem_addr}, 32'd0);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      imem_data  = 16'h0000;
      cFlag      = 1'b0;
      zFlag      = 1'b0;
      exp_pc     = 12'h000;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_pc", {20'd0, pc}, 32'd0);
      chk("reset_aluop", {28'd0, alu_op}, 32'hF);
      chk("reset_we", {31'd0, rf_we}, 32'd0);
      chk("reset_immsel", {31'd0, imm_sel}, 32'd0);
      chk("reset_imm", {16'd0, imm}, 32'd0);
      chk("reset_sels", {24'd0, rf_rd_sel, rf_rs_sel}, 32'd0);
      chk("reset_halted", {31'd0, halted}, 32'd0);
      chk("reset_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_req", {31'd0, imem_req}, 32'd1);

      // LDI r1,0x05 with zero-wait memory.
      issue(16'h2105, 0, 12'h000);
      exec_chk(4'h1, 1'b1, 1'b1, 4'h1, 4'h0);
      chk("ldi_imm", {16'd0, imm}, 32'h0005);
      chk("ldi_req", {31'd0, imem_req}, 32'd0);
      post_chk(12'h001);

      // ADD r1,r2 with three wait cycles.
      issue(16'h0120, 3, 12'h001);
      exec_chk(4'h0, 1'b1, 1'b0, 4'h1, 4'h2);
      post_chk(12'h002);

      // JMP to the top address, then MV wraps the PC to zero.
      issue(16'h3FFF, 0, 12'h002);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'hFFF);
      issue(16'h1230, 1, 12'hFFF);
      exec_chk(4'h1, 1'b1, 1'b0, 4'h2, 4'h3);
      post_chk(12'h000);

`ifdef CTRL_COND_BRANCH_EN
      // Conditional jumps, taken and not taken.
      zFlag = 1'b1;
      issue(16'h4040, 0, 12'h000);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'h040);
      zFlag = 1'b0;
      issue(16'h4080, 0, 12'h040);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'h041);
      cFlag = 1'b1;
      issue(16'h5123, 0, 12'h041);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'h123);
      cFlag = 1'b0;
      issue(16'h5200, 0, 12'h123);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'h124);
      exp_pc = 12'h124;
`else
      // Without conditional branches, JZ is an illegal opcode.
      issue(16'h3055, 0, 12'h000);
      exec_chk(4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
      post_chk(12'h055);
      zFlag = 1'b1;
      issue(16'h4040, 0, 12'h055);
      cyc();
      chk("jz_ill_illegal", {31'd0, illegal}, 32'd1);
      chk("jz_ill_halted", {31'd0, halted}, 32'd1);
      chk("jz_ill_pc", {20'd0, pc}, 32'h055);
      zFlag = 1'b0;
      pulse_rst();
      exp_pc = 12'h000;
`endif

      // HALT: absorbing, PC frozen, fetches stop even if memory answers.
      issue(16'hF000, 0, exp_pc);
      cyc();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_illegal", {31'd0, illegal}, 32'd0);
      imem_valid = 1'b1;
      imem_data  = 16'h2105;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_pc", {20'd0, pc}, {20'd0, exp_pc});
         chk("halt_stay", {31'd0, halted}, 32'd1);
         chk("halt_we", {31'd0, rf_we}, 32'd0);
      end
      imem_valid = 1'b0;
      pulse_rst();

      // Undefined opcode 0x7 at address 1.
      issue(16'h2207, 0, 12'h000);
      exec_chk(4'h1, 1'b1, 1'b1, 4'h2, 4'h0);
      chk("ldi2_imm", {16'd0, imm}, 32'h0007);
      post_chk(12'h001);
      issue(16'h7000, 0, 12'h001);
      cyc();
      chk("ill_illegal", {31'd0, illegal}, 32'd1);
      chk("ill_halted", {31'd0, halted}, 32'd1);
      chk("ill_pc", {20'd0, pc}, 32'h001);
      cyc();
      chk("ill_req", {31'd0, imem_req}, 32'd0);
      pulse_rst();

      // Reset asserted during EXECUTE of an LDI.
      issue(16'h2311, 0, 12'h000);
      exec_chk(4'h1, 1'b1, 1'b1, 4'h3, 4'h1);
      post_chk(12'h001);
      issue(16'h2345, 0, 12'h001);
      exec_chk(4'h1, 1'b1, 1'b1, 4'h3, 4'h4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
      chk("mid_rst_aluop", {28'd0, alu_op}, 32'hF);
      chk("mid_rst_immsel", {31'd0, imm_sel}, 32'd0);
      chk("mid_rst_imm", {16'd0, imm}, 32'd0);
      chk("mid_rst_pc", {20'd0, pc}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_addr", {20'd0, imem_addr}, 32'd0);
      chk("mid_rel_req", {31'd0, imem_req}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
